// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, branch immediate fields, IF/ID bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int INSTR_W  = 32;
  localparam int ADDR_W   = 64;

  // Branch immediate fields: B uses imm26, CBZ/B.cond use imm19.
  localparam int IMM26_HI = 25;
  localparam int IMM26_LO = 0;
  localparam int IMM19_HI = 23;
  localparam int IMM19_LO = 5;
  localparam int IMM26_W  = IMM26_HI - IMM26_LO + 1;
  localparam int IMM19_W  = IMM19_HI - IMM19_LO + 1;

  localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

  // IF/ID pipeline bundle handed to decode.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic               valid;
  } fetch_t;

endpackage

// File: rtl/branch_target_gen.sv
// Branch target generator: picks imm26/imm19, sign-extends, word-scales, adds to br_pc.
// Latency: purely combinational.
// Backpressure: none.
// Ports: uncond_br selects imm26 (B) vs imm19 (CBZ/B.cond); br_instr/br_pc from decode;
//        target = br_pc + (sext(imm) << 2), wrapping modulo 2^64.
module branch_target_gen
  import cpu_pkg::*;
(
  input  logic               uncond_br,
  input  logic [INSTR_W-1:0] br_instr,
  input  logic [ADDR_W-1:0]  br_pc,
  output logic [ADDR_W-1:0]  target
);

  logic [ADDR_W-1:0] imm_sext;
  logic [ADDR_W-1:0] offset;
  // Opcode bits above imm26 carry no target information.
  logic              unused_opcode;

  always_comb begin
    imm_sext = '0;
    if (uncond_br) begin
      imm_sext = {{(ADDR_W-IMM26_W){br_instr[IMM26_HI]}}, br_instr[IMM26_HI:IMM26_LO]};
    end else begin
      imm_sext = {{(ADDR_W-IMM19_W){br_instr[IMM19_HI]}}, br_instr[IMM19_HI:IMM19_LO]};
    end
  end

  // Offsets are in words, so targets from an aligned br_pc stay aligned.
  assign offset        = imm_sext << 2;
  assign target        = br_pc + offset;
  assign unused_opcode = ^br_instr[INSTR_W-1:IMM26_HI+1];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives imem, holds the IF/ID register and a delivered-instruction count.
// Latency: imem_addr = pc combinationally; the instruction at pc reaches if_id_* one edge later.
// Backpressure: stall freezes pc, IF/ID and fetch_count; a branch seen during a stall is ignored.
// Ports: clk/reset (sync, active-high); imem_addr/imem_rdata instruction memory;
//        stall from hazard unit; br_taken/uncond_br/br_instr/br_pc from decode;
//        if_id_instr/if_id_pc/if_id_valid to decode; fetch_count = instructions delivered valid.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 64'd0,
  parameter bit                DELAY_SLOT = 1'b1,
  parameter int                CNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               br_taken,
  input  logic               uncond_br,
  input  logic [INSTR_W-1:0] br_instr,
  input  logic [ADDR_W-1:0]  br_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] br_target;
  logic [CNT_W-1:0]  cnt;
  fetch_t            if_id;
  fetch_t            fetched;
  fetch_t            squashed;

  branch_target_gen u_btg (
    .uncond_br (uncond_br),
    .br_instr  (br_instr),
    .br_pc     (br_pc),
    .target    (br_target)
  );

  assign fetched  = '{instr: imem_rdata, pc: pc, valid: 1'b1};
  // Without a delay slot the instruction fetched alongside the redirect becomes a bubble.
  assign squashed = '{instr: '0, pc: pc, valid: 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      if_id <= '0;
      cnt   <= '0;
    end else if (!stall) begin
      if (br_taken) begin
        pc <= br_target;
        if (DELAY_SLOT) begin
          if_id <= fetched;
          cnt   <= cnt + CNT_ONE;
        end else begin
          if_id <= squashed;
        end
      end else begin
        pc    <= pc + PC_STEP;
        if_id <= fetched;
        cnt   <= cnt + CNT_ONE;
      end
    end
  end

  assign imem_addr   = pc;
  assign if_id_instr = if_id.instr;
  assign if_id_pc    = if_id.pc;
  assign if_id_valid = if_id.valid;
  assign fetch_count = cnt;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: two instances (delay slot kept, 32-bit count / delay slot squashed, 4-bit count)
// share decode-side stimulus; each has its own instruction memory derived from its address.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic        uncond_br;
  logic [31:0] br_instr;
  logic [63:0] br_pc;

  logic [63:0] addr1, pc1, addr0, pc0;
  logic [31:0] rdata1, instr1, cnt1, rdata0, instr0;
  logic        valid1, valid0;
  logic [3:0]  cnt0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hD500_0000 ^ a[31:0] ^ {a[63:56], 24'h0};
  endfunction

  assign rdata1 = mem_word(addr1);
  assign rdata0 = mem_word(addr0);

  if_stage #(.RESET_PC(64'd0), .DELAY_SLOT(1'b1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .imem_addr(addr1), .imem_rdata(rdata1),
    .stall(stall), .br_taken(br_taken), .uncond_br(uncond_br),
    .br_instr(br_instr), .br_pc(br_pc),
    .if_id_instr(instr1), .if_id_pc(pc1), .if_id_valid(valid1), .fetch_count(cnt1)
  );

  if_stage #(.RESET_PC(64'd0), .DELAY_SLOT(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .imem_addr(addr0), .imem_rdata(rdata0),
    .stall(stall), .br_taken(br_taken), .uncond_br(uncond_br),
    .br_instr(br_instr), .br_pc(br_pc),
    .if_id_instr(instr0), .if_id_pc(pc0), .if_id_valid(valid0), .fetch_count(cnt0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state (shared pc, separate IF/ID and counters per instance).
  logic [63:0] m_pc;
  logic [31:0] m1_instr, m1_cnt, m0_instr;
  logic [63:0] m1_pcr, m0_pcr;
  logic        m1_v, m0_v;
  logic [3:0]  m0_cnt;

  typedef struct {
    logic [63:0] a;
    logic [31:0] i1; logic [63:0] p1; logic v1; logic [31:0] c1;
    logic [31:0] i0; logic [63:0] p0; logic v0; logic [3:0]  c0;
  } exp_t;

  exp_t sb[$];

  function automatic logic [63:0] ref_target(input logic u, input logic [31:0] ins, input logic [63:0] bpc);
    longint imm;
    if (u) begin
      imm = longint'(ins[25:0]);
      if (ins[25]) imm = imm - 64'sd67108864;
    end else begin
      imm = longint'(ins[23:5]);
      if (ins[23]) imm = imm - 64'sd524288;
    end
    return bpc + 64'(imm * 4);
  endfunction

  // Drive one cycle of stimulus, predict the post-edge state, queue it, and return just after the edge.
  task automatic drive(input logic r, input logic s, input logic b, input logic u,
                       input logic [31:0] ins, input logic [63:0] bpc);
    exp_t e;
    @(negedge clk);
    reset = r; stall = s; br_taken = b; uncond_br = u; br_instr = ins; br_pc = bpc;
    if (r) begin
      m_pc = 64'd0;
      m1_instr = '0; m1_pcr = '0; m1_v = 1'b0; m1_cnt = '0;
      m0_instr = '0; m0_pcr = '0; m0_v = 1'b0; m0_cnt = '0;
    end else if (!s) begin
      m1_instr = mem_word(m_pc); m1_pcr = m_pc; m1_v = 1'b1; m1_cnt = m1_cnt + 32'd1;
      if (b) begin
        m0_instr = '0; m0_v = 1'b0;
      end else begin
        m0_instr = mem_word(m_pc); m0_pcr = m_pc; m0_v = 1'b1; m0_cnt = m0_cnt + 4'd1;
      end
      m_pc = b ? ref_target(u, ins, bpc) : m_pc + 64'd4;
    end
    e = '{a: m_pc, i1: m1_instr, p1: m1_pcr, v1: m1_v, c1: m1_cnt,
          i0: m0_instr, p0: m0_pcr, v0: m0_v, c0: m0_cnt};
    sb.push_back(e);
    @(posedge clk);
    #3;
  endtask

  // Scoreboard: compare every queued prediction against both instances just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({addr1, instr1, pc1, valid1, cnt1} !== {e.a, e.i1, e.p1, e.v1, e.c1}) begin
        n_fail++;
        $display("FAIL sb_dut1 t=%0t: got addr=%h instr=%h pc=%h v=%b cnt=%0d, want addr=%h instr=%h pc=%h v=%b cnt=%0d",
                 $time, addr1, instr1, pc1, valid1, cnt1, e.a, e.i1, e.p1, e.v1, e.c1);
      end
      n_checks++;
      if ({addr0, instr0, valid0, cnt0} !== {e.a, e.i0, e.v0, e.c0} || (e.v0 && pc0 !== e.p0)) begin
        n_fail++;
        $display("FAIL sb_dut0 t=%0t: got addr=%h instr=%h pc=%h v=%b cnt=%0d, want addr=%h instr=%h pc=%h v=%b cnt=%0d",
                 $time, addr0, instr0, pc0, valid0, cnt0, e.a, e.i0, e.p0, e.v0, e.c0);
      end
    end
  end

  task automatic test_reset();
    drive(1, 0, 0, 0, 32'h0, 64'h0);
    drive(1, 0, 0, 0, 32'h0, 64'h0);
    n_checks++;
    if ({addr1, valid1, pc1, instr1, cnt1} !== {64'h0, 1'b0, 64'h0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got addr=%h v=%b pc=%h instr=%h cnt=%0d, want all zero", addr1, valid1, pc1, instr1, cnt1);
    end
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 0, 0, 32'h0, 64'h0);
      n_checks++;
      if (addr1 !== 64'(4 * k) || pc1 !== 64'(4 * (k - 1)) || valid1 !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_seq%0d: got addr=%h pc=%h v=%b, want addr=%h pc=%h v=1", k, addr1, pc1, valid1, 64'(4 * k), 64'(4 * (k - 1)));
      end
    end
    n_checks++;
    if (cnt1 !== 32'd3) begin
      n_fail++;
      $display("FAIL reset_count: got %0d want 3", cnt1);
    end
  endtask

  task automatic test_stall();
    drive(0, 0, 0, 0, 32'h0, 64'h0);
    n_checks++;
    if (addr1 !== 64'h10) begin
      n_fail++;
      $display("FAIL stall_pre: got addr=%h want 10", addr1);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 32'h0, 64'h0);
      n_checks++;
      if (addr1 !== 64'h10 || pc1 !== 64'hC || instr1 !== mem_word(64'hC) || cnt1 !== 32'd4) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got addr=%h pc=%h instr=%h cnt=%0d, want addr=10 pc=c instr=%h cnt=4",
                 k, addr1, pc1, instr1, cnt1, mem_word(64'hC));
      end
    end
    drive(0, 0, 0, 0, 32'h0, 64'h0);
    n_checks++;
    if (addr1 !== 64'h14) begin
      n_fail++;
      $display("FAIL stall_release: got addr=%h want 14", addr1);
    end
  endtask

  task automatic test_branch_backward();
    drive(0, 0, 1, 1, {6'b000101, 26'h3FF_FFFC}, 64'h40);
    n_checks++;
    if (addr1 !== 64'h30 || valid1 !== 1'b1 || pc1 !== 64'h14 || valid0 !== 1'b0 || instr0 !== 32'h0) begin
      n_fail++;
      $display("FAIL b_backward: got addr=%h v1=%b pc1=%h v0=%b i0=%h, want addr=30 v1=1 pc1=14 v0=0 i0=0",
               addr1, valid1, pc1, valid0, instr0);
    end
    drive(0, 0, 0, 0, 32'h0, 64'h0);
    n_checks++;
    if (valid0 !== 1'b1 || pc0 !== 64'h30 || addr0 !== 64'h34) begin
      n_fail++;
      $display("FAIL b_after_bubble: got v0=%b pc0=%h addr=%h, want v0=1 pc0=30 addr=34", valid0, pc0, addr0);
    end
  endtask

  task automatic test_cbz_forward();
    drive(0, 0, 1, 0, {8'hB4, 19'd5, 5'd3}, 64'h100);
    n_checks++;
    if (addr1 !== 64'h114) begin
      n_fail++;
      $display("FAIL cbz_forward: got addr=%h want 114", addr1);
    end
  endtask

  task automatic test_br_while_stalled();
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 1, 1, {6'b000101, 26'd8}, 64'h200);
      n_checks++;
      if (addr1 !== 64'h114) begin
        n_fail++;
        $display("FAIL br_stalled%0d: got addr=%h want 114", k, addr1);
      end
    end
    drive(0, 0, 1, 1, {6'b000101, 26'd8}, 64'h200);
    n_checks++;
    if (addr1 !== 64'h220) begin
      n_fail++;
      $display("FAIL br_unstalled: got addr=%h want 220", addr1);
    end
  endtask

  task automatic test_wrap();
    drive(0, 0, 1, 0, {8'hB4, 19'h7FFFE, 5'd0}, 64'h4);
    n_checks++;
    if (addr1 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_fail++;
      $display("FAIL target_wrap: got addr=%h want fffffffffffffffc", addr1);
    end
    drive(0, 0, 0, 0, 32'h0, 64'h0);
    n_checks++;
    if (addr1 !== 64'h0 || pc1 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_fail++;
      $display("FAIL pc_wrap: got addr=%h pc=%h want addr=0 pc=fffffffffffffffc", addr1, pc1);
    end
    for (int k = 0; k < 20 && m0_cnt != 4'hF; k++) drive(0, 0, 0, 0, 32'h0, 64'h0);
    n_checks++;
    if (cnt0 !== 4'hF) begin
      n_fail++;
      $display("FAIL count_pre_wrap: got %0d want 15", cnt0);
    end
    drive(0, 0, 0, 0, 32'h0, 64'h0);
    n_checks++;
    if (cnt0 !== 4'h0) begin
      n_fail++;
      $display("FAIL count_wrap: got %0d want 0", cnt0);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 0, 0, 32'h0, 64'h0);
    drive(1, 1, 1, 1, {6'b000101, 26'd64}, 64'h800);
    n_checks++;
    if ({addr1, valid1, cnt1, cnt0} !== {64'h0, 1'b0, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_stall: got addr=%h v=%b cnt1=%0d cnt0=%0d, want 0/0/0/0", addr1, valid1, cnt1, cnt0);
    end
    drive(0, 0, 0, 0, {6'b000101, 26'd64}, 64'h800);
    n_checks++;
    if (addr1 !== 64'h4 || pc1 !== 64'h0 || valid1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_no_redirect: got addr=%h pc=%h v=%b want addr=4 pc=0 v=1", addr1, pc1, valid1);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins, hi, lo;
    for (int k = 0; k < 60; k++) begin
      ins = $urandom;
      hi  = $urandom;
      lo  = $urandom;
      drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), ins, {hi, lo[31:2], 2'b00});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; uncond_br = 1'b0; br_instr = '0; br_pc = '0;
    m_pc = '0; m1_instr = '0; m1_pcr = '0; m1_v = 1'b0; m1_cnt = '0;
    m0_instr = '0; m0_pcr = '0; m0_v = 1'b0; m0_cnt = '0;
    test_reset();
    test_stall();
    test_branch_backward();
    test_cbz_forward();
    test_br_while_stalled();
    test_wrap();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
